// File: rtl/bcd_to_fnd_decoder.sv
// Registered BCD/hex to 7-segment font and one-hot digit enable driver.
// Define FND_HEX_EN to display A-F; otherwise 10..15 blank the segments.
module bcd_to_fnd_decoder #(
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [3:0] i_value,
  input  logic [1:0] i_digitSelect,
  output logic [7:0] o_font,
  output logic [3:0] o_digit
);

  localparam logic [7:0] FONT_OFF  = {8{SEG_ACTIVE_LOW}};
  localparam logic [3:0] DIGIT_OFF = {4{DIGIT_ACTIVE_LOW}};

  logic [7:0] seg_on;
  logic [3:0] dig_on;
  logic [7:0] font_d, font_q;
  logic [3:0] digit_d, digit_q;

  // Active-high {dp,g,f,e,d,c,b,a}; dp is never lit.
  always_comb begin
    seg_on = 8'h00;
    case (i_value)
      4'h0: seg_on = 8'h3F;
      4'h1: seg_on = 8'h06;
      4'h2: seg_on = 8'h5B;
      4'h3: seg_on = 8'h4F;
      4'h4: seg_on = 8'h66;
      4'h5: seg_on = 8'h6D;
      4'h6: seg_on = 8'h7D;
      4'h7: seg_on = 8'h07;
      4'h8: seg_on = 8'h7F;
      4'h9: seg_on = 8'h6F;
`ifdef FND_HEX_EN
      4'hA: seg_on = 8'h77;
      4'hB: seg_on = 8'h7C;
      4'hC: seg_on = 8'h39;
      4'hD: seg_on = 8'h5E;
      4'hE: seg_on = 8'h79;
      4'hF: seg_on = 8'h71;
`endif
      default: seg_on = 8'h00;
    endcase
  end

  always_comb begin
    dig_on  = 4'b0001 << i_digitSelect;
    font_d  = FONT_OFF;
    digit_d = DIGIT_OFF;
    if (i_en) begin
      font_d  = seg_on ^ FONT_OFF;
      digit_d = dig_on ^ DIGIT_OFF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      font_q  <= FONT_OFF;
      digit_q <= DIGIT_OFF;
    end else begin
      font_q  <= font_d;
      digit_q <= digit_d;
    end
  end

  assign o_font  = font_q;
  assign o_digit = digit_q;

endmodule

// File: tb/tb_bcd_to_fnd_decoder.sv
// Bench for bcd_to_fnd_decoder: directed cases plus random stimulus,
// on an active-low instance and an active-high instance.
module tb_bcd_to_fnd_decoder;

`ifdef FND_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] val;
  logic [1:0] sel;
  logic [7:0] font_l, font_h;
  logic [3:0] dig_l, dig_h;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] lut [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  always #5 clk = ~clk;

  bcd_to_fnd_decoder u_lo (
    .i_clk(clk), .i_reset(rst), .i_en(en),
    .i_value(val), .i_digitSelect(sel),
    .o_font(font_l), .o_digit(dig_l)
  );

  bcd_to_fnd_decoder #(
    .SEG_ACTIVE_LOW(1'b0), .DIGIT_ACTIVE_LOW(1'b0)
  ) u_hi (
    .i_clk(clk), .i_reset(rst), .i_en(en),
    .i_value(val), .i_digitSelect(sel),
    .o_font(font_h), .o_digit(dig_h)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_font(bit r, bit e, int v);
    if (r || !e) return 8'hFF;
    if (v > 9 && !HEX) return 8'hFF;
    return lut[v];
  endfunction

  function automatic logic [3:0] ref_digit(bit r, bit e, int s);
    if (r || !e) return 4'hF;
    return ~(4'(1) << s);
  endfunction

  task automatic step(input bit r, input bit e,
                      input int v, input int s,
                      input string tag);
    logic [7:0] ef;
    logic [3:0] ed;
    @(negedge clk);
    rst = r; en = e; val = 4'(v); sel = 2'(s);
    ef = ref_font(r, e, v);
    ed = ref_digit(r, e, s);
    @(posedge clk);
    #1;
    chk({tag, ".font"}, font_l, ef);
    chk({tag, ".digit"}, {4'h0, dig_l}, {4'h0, ed});
    chk({tag, ".font_ah"}, font_h, ~ef);
    chk({tag, ".digit_ah"}, {4'h0, dig_h}, {4'h0, ~ed});
    chk({tag, ".onehot"},
        8'($countones(~dig_l) > 1), 8'd0);
  endtask

  initial begin
    int vseq [8] = '{0, 5, 10, 15, 2, 3, 4, 8};
    rst = 1'b1; en = 1'b1; val = 4'h8; sel = 2'd0;

    step(1, 1, 8, 0, "rst0");
    step(1, 1, 8, 0, "rst1");
    step(0, 1, 8, 0, "rel");

    for (int i = 0; i < 4; i++) step(0, 1, 8, i, "dsel");
    foreach (vseq[i]) step(0, 1, vseq[i], 0, "val");

    step(0, 0, 5, 1, "dis");
    step(0, 1, 10, 2, "hexA");
    step(0, 1, 9, 2, "nine");

    step(0, 1, 1, 0, "pair0");
    step(0, 1, 7, 3, "pair1");
    step(0, 1, 2, 1, "pair2");
    step(1, 1, 6, 2, "midrst");
    step(0, 1, 6, 2, "after");

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 15) == 0,
           $urandom_range(0, 4) != 0,
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)),
           "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_fnd_decoder.md
BCD_TO_FND_DECODER -- requirements
Module: bcd_to_fnd_decoder

Interface
REQ-001 The block SHALL use one clock, i_clk, with a synchronous, active-high reset, i_reset.
REQ-002 The block SHALL expose these parameters (name, default, meaning):
- SEG_ACTIVE_LOW, 1, segment outputs drive 0 to light a segment.
- DIGIT_ACTIVE_LOW, 1, digit-enable outputs drive 0 to select a digit.

REQ-003 The block SHALL expose these ports (name, direction, width, meaning):
- i_clk, in, 1, rising-edge clock.
- i_reset, in, 1, synchronous active-high reset.
- i_en, in, 1, display enable.
- i_value, in, 4, BCD/hex value to display.
- i_digitSelect, in, 2, index of the digit to light (0..3).
- o_font, out, 8, segment pattern {dp,g,f,e,d,c,b,a}.
- o_digit, out, 4, one-hot digit enable; bit n selects digit n.

Function
REQ-004 o_font and o_digit SHALL be registered, so inputs sampled at rising edge N appear after edge N (1-cycle latency), with no combinational input-to-output path.
REQ-005 With i_en=1, o_font SHALL take the active-high pattern for i_value, inverted when SEG_ACTIVE_LOW=1; dp (bit 7) SHALL always be off.
REQ-006 The active-low patterns for values 0..F SHALL be C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (hex), displaying 0-9, A, b, C, d, E, F.
REQ-007 With i_en=1, o_digit SHALL assert exactly bit i_digitSelect, giving 1110,1101,1011,0111 for selects 0..3 when DIGIT_ACTIVE_LOW=1, or the inverse when it is 0.
REQ-008 With i_en=0, on the next edge o_font SHALL be all segments off (FF when active-low) and o_digit SHALL be all digits off (1111 when active-low).
REQ-009 o_digit SHALL never have more than one digit active in any cycle.
REQ-010 Changing i_value and i_digitSelect in the same cycle SHALL update both outputs together on the same edge.
REQ-011 Unknown (X) inputs SHALL NOT be masked; behaviour under X is unspecified.

Reset
REQ-012 While i_reset=1 at a rising edge, o_font SHALL become all-off and o_digit all-off, with reset taking priority over i_en.
REQ-013 Reset asserted mid-operation SHALL blank the outputs on that edge.
REQ-014 After reset deasserts, the first edge SHALL load outputs normally from the sampled inputs.

Configuration
REQ-015 The block SHALL use macro FND_HEX_EN.
- Defined: values A-F display per REQ-006.
- Not defined: values A-F (10..15) produce an all-off o_font.
- In both cases o_digit behaves normally and values 0-9 are unaffected.

Verification
REQ-016 The bench SHALL cover these directed scenarios (SEG_ACTIVE_LOW=1, DIGIT_ACTIVE_LOW=1, FND_HEX_EN defined unless noted):
- i_reset=1 for 2 edges with i_en=1, i_value=8 -> o_font=FF, o_digit=1111; first edge after release -> o_font=80.
- i_en=1, i_digitSelect stepping 0,1,2,3 -> o_digit=1110,1101,1011,0111, each one edge later.
- i_en=1, i_value stepping 0,5,A,F,2,3,4,8 -> o_font=C0,92,88,8E,A4,B0,99,80.
- i_en=0 with any i_value/i_digitSelect (e.g. 5/01) -> o_font=FF, o_digit=1111.
- FND_HEX_EN undefined, i_en=1, i_value=A -> o_font=FF; i_value=9 -> o_font=90.
- i_value and i_digitSelect change on the same cycle -> both outputs update on the same following edge, and o_digit stays one-hot throughout.
